// File: rtl/board_refresh_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : board_refresh_if
//  Purpose  : Signal bundle between the board refresh sequencer, the player
//             block, the board RAM and the display scanner.
//  Revision : 1.0  initial release
// ============================================================================
interface board_refresh_if #(
    parameter int COLS = 10
);
    logic              refresh;
    logic [19:0]       cell_x;
    logic [19:0]       cell_y;
    logic [4:0]        ram_addr;
    logic              ram_we;
    logic [COLS-1:0]   ram_wdata;
    logic [COLS-1:0]   ram_rdata;
    logic [4:0]        disp_addr;
    logic [COLS-1:0]   disp_data;
    logic              disp_valid;
    logic              busy;
    logic              refresh_done;
    logic [9:0]        lines_total;
    logic [15:0]       score;
    logic [2:0]        last_lines;

    // Sequencer side
    modport master (
        input  refresh, cell_x, cell_y, ram_rdata, disp_addr,
        output ram_addr, ram_we, ram_wdata, disp_data, disp_valid,
               busy, refresh_done, lines_total, score, last_lines
    );

    // Player / RAM / display side
    modport slave (
        output refresh, cell_x, cell_y, ram_rdata, disp_addr,
        input  ram_addr, ram_we, ram_wdata, disp_data, disp_valid,
               busy, refresh_done, lines_total, score, last_lines
    );
endinterface
`default_nettype wire

// File: rtl/board_refresh_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : board_refresh_ctrl
//  Purpose  : Board RAM sequencer. Merges a landed piece, compacts full rows
//             downward, zero-fills the top, keeps line/score counters and
//             lends the RAM port to the display scanner while idle.
//  Revision : 1.0  initial release
// ============================================================================
module board_refresh_ctrl #(
    parameter int COLS = 10,
    parameter int ROWS = 20
) (
    input  logic            clk,
    input  logic            rstn,
    board_refresh_if.master bus
);

    localparam logic [2:0] S_INIT     = 3'd0;
    localparam logic [2:0] S_IDLE     = 3'd1;
    localparam logic [2:0] S_MERGE_RD = 3'd2;
    localparam logic [2:0] S_MERGE_WR = 3'd3;
    localparam logic [2:0] S_SCAN_RD  = 3'd4;
    localparam logic [2:0] S_SCAN_EV  = 3'd5;
    localparam logic [2:0] S_FILL     = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    localparam logic [4:0]      c_ROWS     = 5'(ROWS);
    localparam logic [4:0]      c_ROW_LAST = 5'(ROWS - 1);
    localparam logic [4:0]      c_COLS     = 5'(COLS);
    localparam logic [COLS-1:0] c_ONE      = COLS'(1);

    logic [2:0]      r_state, w_next;
    logic [4:0]      r_row;
    logic [19:0]     r_cx, r_cy;
    logic [1:0]      r_idx;
    logic [4:0]      r_src, r_dst, r_rows_left, r_k;
    logic            r_disp_valid;
    logic [9:0]      r_lines_total;
    logic [15:0]     r_score;
    logic [2:0]      r_last_lines;

    logic [4:0]      w_x, w_y, w_k_nxt, w_pts;
    logic            w_cell_ok, w_full, w_last_cell;
    logic            w_busy, w_we, w_done;
    logic [4:0]      w_addr;
    logic [COLS-1:0] w_wdata;
    logic [10:0]     w_lines_sum;
    logic [16:0]     w_score_sum;

    // Current cell coordinates and derived status
    always_comb begin
        case (r_idx)
            2'd0:    begin w_x = r_cx[4:0];   w_y = r_cy[4:0];   end
            2'd1:    begin w_x = r_cx[9:5];   w_y = r_cy[9:5];   end
            2'd2:    begin w_x = r_cx[14:10]; w_y = r_cy[14:10]; end
            default: begin w_x = r_cx[19:15]; w_y = r_cy[19:15]; end
        endcase
        w_cell_ok   = (w_y < c_ROWS) && (w_x < c_COLS);
        w_last_cell = (r_idx == 2'd3);
        w_full      = &bus.ram_rdata;
        // Cleared-row count including the row being evaluated this cycle
        w_k_nxt     = (r_state == S_SCAN_EV && w_full) ? r_k + 5'd1 : r_k;
        case (w_k_nxt)
            5'd0:    w_pts = 5'd0;
            5'd1:    w_pts = 5'd1;
            5'd2:    w_pts = 5'd3;
            5'd3:    w_pts = 5'd5;
            default: w_pts = 5'd8;
        endcase
        w_lines_sum = {1'b0, r_lines_total} + 11'(w_k_nxt);
        w_score_sum = {1'b0, r_score} + 17'(w_pts);
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_INIT;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT:     if (r_row == c_ROW_LAST) w_next = S_IDLE;
            S_IDLE:     if (bus.refresh) w_next = S_MERGE_RD;
            S_MERGE_RD: if (w_cell_ok)        w_next = S_MERGE_WR;
                        else if (w_last_cell) w_next = S_SCAN_RD;
            S_MERGE_WR: w_next = w_last_cell ? S_SCAN_RD : S_MERGE_RD;
            S_SCAN_RD:  w_next = S_SCAN_EV;
            S_SCAN_EV:  if (r_rows_left == 5'd1)
                            w_next = (w_k_nxt != 5'd0) ? S_FILL : S_DONE;
                        else
                            w_next = S_SCAN_RD;
            S_FILL:     if (r_dst == 5'd0) w_next = S_DONE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Output logic: RAM port ownership, write strobes and completion pulse
    always_comb begin
        w_busy  = 1'b1;
        w_addr  = 5'd0;
        w_we    = 1'b0;
        w_wdata = '0;
        w_done  = 1'b0;
        case (r_state)
            S_INIT: begin
                w_addr = r_row;
                // no write strobe while reset is still held
                w_we   = rstn;
            end
            S_IDLE: begin
                w_busy = 1'b0;
                w_addr = bus.disp_addr;
            end
            S_MERGE_RD: w_addr = w_y;
            S_MERGE_WR: begin
                w_addr  = w_y;
                w_we    = 1'b1;
                w_wdata = bus.ram_rdata | (c_ONE << w_x);
            end
            S_SCAN_RD: w_addr = r_src;
            S_SCAN_EV: begin
                w_addr  = r_dst;
                w_we    = ~w_full;
                w_wdata = bus.ram_rdata;
            end
            S_FILL: begin
                w_addr = r_dst;
                w_we   = 1'b1;
            end
            default: w_done = 1'b1;
        endcase
    end

    // Datapath: cell latch, scan pointers, counters and display-valid flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_row         <= 5'd0;
            r_cx          <= 20'd0;
            r_cy          <= 20'd0;
            r_idx         <= 2'd0;
            r_src         <= 5'd0;
            r_dst         <= 5'd0;
            r_rows_left   <= 5'd0;
            r_k           <= 5'd0;
            r_disp_valid  <= 1'b0;
            r_lines_total <= 10'd0;
            r_score       <= 16'd0;
            r_last_lines  <= 3'd0;
        end else begin
            r_disp_valid <= ~w_busy;
            case (r_state)
                S_INIT: r_row <= r_row + 5'd1;
                S_IDLE: if (bus.refresh) begin
                    r_cx        <= bus.cell_x;
                    r_cy        <= bus.cell_y;
                    r_idx       <= 2'd0;
                    r_src       <= c_ROW_LAST;
                    r_dst       <= c_ROW_LAST;
                    r_rows_left <= c_ROWS;
                    r_k         <= 5'd0;
                end
                S_MERGE_RD: if (!w_cell_ok) r_idx <= r_idx + 2'd1;
                S_MERGE_WR: r_idx <= r_idx + 2'd1;
                S_SCAN_EV: begin
                    r_k         <= w_k_nxt;
                    r_src       <= r_src - 5'd1;
                    r_rows_left <= r_rows_left - 5'd1;
                    if (!w_full) r_dst <= r_dst - 5'd1;
                end
                S_FILL: r_dst <= r_dst - 5'd1;
                default: ;
            endcase
            // Counters land on the edge entering DONE, alongside refresh_done
            if (w_next == S_DONE) begin
                r_last_lines  <= w_k_nxt[2:0];
                r_lines_total <= w_lines_sum[10] ? 10'h3FF   : w_lines_sum[9:0];
                r_score       <= w_score_sum[16] ? 16'hFFFF  : w_score_sum[15:0];
            end
        end
    end

    assign bus.ram_addr     = w_addr;
    assign bus.ram_we       = w_we;
    assign bus.ram_wdata    = w_wdata;
    assign bus.busy         = w_busy;
    assign bus.refresh_done = w_done;
    assign bus.disp_data    = bus.ram_rdata;
    assign bus.disp_valid   = r_disp_valid;
    assign bus.lines_total  = r_lines_total;
    assign bus.score        = r_score;
    assign bus.last_lines   = r_last_lines;

endmodule
`default_nettype wire

// File: tb/tb_board_refresh_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_board_refresh_ctrl
//  Purpose  : Scoreboard bench for board_refresh_ctrl with a behavioural
//             1-cycle-latency board RAM.
//  Revision : 1.0  initial release
// ============================================================================
module tb_board_refresh_ctrl;
    localparam int COLS = 10;
    localparam int ROWS = 20;

    typedef struct {
        int          issue;
        int          lat;
        logic [2:0]  last;
        logic [15:0] score;
        logic [9:0]  lines;
    } done_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    board_refresh_if #(.COLS(COLS)) bus();

    board_refresh_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    done_t           dq[$];
    logic [COLS-1:0] rq[$];

    logic [COLS-1:0] mem [0:31];
    logic            pre_we   = 1'b0;
    logic [4:0]      pre_addr = 5'd0;
    logic [COLS-1:0] pre_data = '0;
    logic            disp_req = 1'b0;
    logic            req_d    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Board RAM model: synchronous write, registered read
    always @(posedge clk) begin
        if (pre_we)           mem[pre_addr]     <= pre_data;
        else if (bus.ram_we)  mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    always @(posedge clk) req_d <= disp_req;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic done_t mk(input int lat, input int last, input int score, input int lines);
        done_t e;
        e.issue = 0;
        e.lat   = lat;
        e.last  = 3'(last);
        e.score = 16'(score);
        e.lines = 10'(lines);
        return e;
    endfunction

    function automatic logic [19:0] pk(input int a, input int b, input int c, input int d);
        return {5'(d), 5'(c), 5'(b), 5'(a)};
    endfunction

    // Monitor: pops expected completions and display reads as the DUT presents them
    always @(negedge clk) begin
        done_t           e;
        logic [COLS-1:0] r;
        if (rstn && bus.refresh_done) begin
            if (dq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got refresh_done=1 expected none at cycle %0d", cyc);
            end else begin
                e = dq.pop_front();
                chk("last_lines",  32'(bus.last_lines),  32'(e.last));
                chk("score",       32'(bus.score),       32'(e.score));
                chk("lines_total", 32'(bus.lines_total), 32'(e.lines));
                chk("done_latency", 32'(cyc - e.issue),  32'(e.lat));
            end
        end
        if (req_d) begin
            chk("disp_valid", 32'(bus.disp_valid), 32'd1);
            if (rq.size() != 0) begin
                r = rq.pop_front();
                chk("disp_data", 32'(bus.disp_data), 32'(r));
            end
        end
    end

    task automatic poke(input int row, input logic [COLS-1:0] val);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = 5'(row); pre_data = val;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic disp_rd(input int row, input logic [COLS-1:0] exp);
        @(negedge clk);
        bus.disp_addr = 5'(row);
        disp_req      = 1'b1;
        rq.push_back(exp);
        @(negedge clk);
        disp_req = 1'b0;
    endtask

    task automatic issue(input logic [19:0] cx, input logic [19:0] cy, input bit track, input done_t e);
        done_t t;
        t = e;
        @(negedge clk);
        bus.cell_x  = cx;
        bus.cell_y  = cy;
        bus.refresh = 1'b1;
        if (track) begin
            t.issue = cyc;
            dq.push_back(t);
        end
        @(negedge clk);
        bus.refresh = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(bus.busy), 32'd0);
        @(negedge clk);
    endtask

    // Release reset and follow the ROWS-cycle clearing sweep
    task automatic run_init();
        int i    = 0;
        int good = 0;
        @(negedge clk);
        rstn = 1'b1;
        #1;
        while (bus.busy && i < 100) begin
            if (bus.ram_we && bus.ram_addr == 5'(i) && bus.ram_wdata == '0) good++;
            i++;
            @(negedge clk);
            #1;
        end
        chk("init_cycles", 32'(i), 32'(ROWS));
        chk("init_zero_writes", 32'(good), 32'(ROWS));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},         32'(bus.busy),         32'd1);
        chk({tag, "_ram_we"},       32'(bus.ram_we),       32'd0);
        chk({tag, "_refresh_done"}, 32'(bus.refresh_done), 32'd0);
        chk({tag, "_disp_valid"},   32'(bus.disp_valid),   32'd0);
        chk({tag, "_score"},        32'(bus.score),        32'd0);
        chk({tag, "_lines_total"},  32'(bus.lines_total),  32'd0);
        chk({tag, "_last_lines"},   32'(bus.last_lines),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.refresh   = 1'b0;
        bus.cell_x    = '0;
        bus.cell_y    = '0;
        bus.disp_addr = '0;

        // Reset state, then the clearing sweep
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        run_init();
        chk("post_init_score", 32'(bus.score),       32'd0);
        chk("post_init_lines", 32'(bus.lines_total), 32'd0);
        disp_rd(0, '0);
        disp_rd(19, '0);

        // Single line: row 19 3F0 completed by cols 0..3, row 18 drops to 19.
        // Four valid cells: 1 + 8 + 40 + k(1) = 50 cycles.
        poke(19, 10'h3F0);
        poke(18, 10'h2A5);
        issue(pk(0, 1, 2, 3), pk(19, 19, 19, 19), 1'b1, mk(50, 1, 1, 1));
        repeat (3) @(negedge clk);
        chk("busy_during_op",       32'(bus.busy),       32'd1);
        chk("disp_valid_during_op", 32'(bus.disp_valid), 32'd0);
        wait_idle();
        disp_rd(19, 10'h2A5);
        disp_rd(18, 10'h000);
        disp_rd(0,  10'h000);

        // Tetris: rows 16..19 full after merging col 9; rows 15/14 move to 19/18.
        // Score 1 + 8 = 9, lines 5, latency 49 + 4 = 53.
        poke(16, 10'h3FF);
        poke(17, 10'h3FF);
        poke(18, 10'h3FF);
        poke(19, 10'h1FF);
        poke(15, 10'h0C3);
        poke(14, 10'h101);
        issue(pk(9, 9, 9, 9), pk(16, 17, 18, 19), 1'b1, mk(53, 4, 9, 5));
        wait_idle();
        disp_rd(19, 10'h0C3);
        disp_rd(18, 10'h101);
        disp_rd(17, 10'h000);
        disp_rd(3,  10'h000);
        disp_rd(0,  10'h000);

        // Three merges plus a skipped cell (x=31): 1 + 7 + 40 + 0 = 48 cycles.
        // A stray refresh mid-scan must not produce a second completion.
        issue(pk(4, 5, 4, 31), pk(2, 2, 3, 3), 1'b1, mk(48, 0, 9, 5));
        repeat (20) @(negedge clk);
        bus.cell_x  = pk(0, 1, 2, 3);
        bus.cell_y  = pk(0, 0, 0, 0);
        bus.refresh = 1'b1;
        @(negedge clk);
        bus.refresh = 1'b0;
        wait_idle();
        disp_rd(2,  10'h030);
        disp_rd(3,  10'h010);
        disp_rd(19, 10'h0C3);
        disp_rd(18, 10'h101);
        disp_rd(0,  10'h000);
        repeat (60) @(negedge clk);

        // Async reset in SCAN_EV: all cells skipped, so SCAN_EV is the
        // sixth cycle after the refresh edge.
        issue(pk(31, 31, 31, 31), pk(0, 0, 0, 0), 1'b0, mk(0, 0, 0, 0));
        repeat (5) @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk_reset_outputs("midscan_reset");
        run_init();
        disp_rd(19, '0);
        disp_rd(18, '0);
        disp_rd(2,  '0);

        repeat (3) @(negedge clk);
        chk("pending_done_queue", 32'(dq.size()), 32'd0);
        chk("pending_read_queue", 32'(rq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
